// File: rtl/vga_sync_decoder_if.sv
// VGA receive link bundle: sync/RGB pins toward the decoder and the decoded
// pixel stream plus timing status back out. The source/sink side (loopback,
// external source model, capture RAM) uses master; the decoder uses slave.
interface vga_sync_decoder_if;
    logic        iVGA_H_SYNC;
    logic        iVGA_V_SYNC;
    logic [3:0]  iVGA_R;
    logic [3:0]  iVGA_G;
    logic [3:0]  iVGA_B;
    logic [9:0]  oCoord_X;
    logic [9:0]  oCoord_Y;
    logic [19:0] oAddress;
    logic [11:0] oData;
    logic        oPixel_Valid;
    logic        oFrame_Start;
    logic [9:0]  oLine_Len;
    logic [9:0]  oFrame_Lines;
    logic        oLocked;

    modport master (
        output iVGA_H_SYNC, iVGA_V_SYNC, iVGA_R, iVGA_G, iVGA_B,
        input  oCoord_X, oCoord_Y, oAddress, oData, oPixel_Valid,
        input  oFrame_Start, oLine_Len, oFrame_Lines, oLocked
    );

    modport slave (
        input  iVGA_H_SYNC, iVGA_V_SYNC, iVGA_R, iVGA_G, iVGA_B,
        output oCoord_X, oCoord_Y, oAddress, oData, oPixel_Valid,
        output oFrame_Start, oLine_Len, oFrame_Lines, oLocked
    );
endinterface

// File: rtl/vga_sync_decoder.sv
// VGA receive-side timing recovery. Measures the hsync period and lines per
// frame, locks once consecutive frames agree, then streams active pixels with
// coordinates and a linear frame-buffer address two cycles after the pins.
module vga_sync_decoder #(
    parameter int H_BACK      = 144,
    parameter int H_ACT       = 640,
    parameter int V_BACK      = 35,
    parameter int V_ACT       = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic            iCLK,
    input  logic            iRST_N,
    vga_sync_decoder_if.slave vga
);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [9:0]  C_MAX    = 10'd1023;
    localparam logic [9:0]  C_H_LO   = 10'(H_BACK);
    localparam logic [9:0]  C_H_HI   = 10'(H_BACK + H_ACT);
    localparam logic [9:0]  C_V_LO   = 10'(V_BACK);
    localparam logic [9:0]  C_V_HI   = 10'(V_BACK + V_ACT);
    localparam logic [19:0] C_H_ACT  = 20'(H_ACT);
    localparam logic [2:0]  C_LOCK   = 3'(LOCK_FRAMES);

    // Counters saturate instead of wrapping so a dead sync never aliases
    // back into the active window.
    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        if (v == C_MAX) begin
            sat_inc = v;
        end else begin
            sat_inc = v + 10'd1;
        end
    endfunction

    // input stage
    logic        r_hs, r_hs_d, r_vs, r_vs_d;
    logic [11:0] r_rgb;
    // timing state
    logic [9:0]  r_hcnt, r_vcnt;
    logic        r_v_pend;
    logic [9:0]  r_line_len, r_frame_lines;
    state_t      r_state;
    logic [2:0]  r_match;
    logic        r_first, r_line_bad;
    // output registers
    logic        r_locked, r_valid, r_fstart;
    logic [9:0]  r_x, r_y;
    logic [19:0] r_addr;
    logic [11:0] r_data;

    logic        w_h_edge, w_v_edge;
    logic [9:0]  w_hcnt, w_vcnt;
    logic [9:0]  w_line_len, w_frame_lines;
    logic        w_timeout, w_line_mis, w_frame_mis;
    state_t      w_state_nx;
    logic [2:0]  w_match_nx, w_match_inc;
    logic        w_first_nx, w_line_bad_nx;
    logic        w_active, w_keep, w_pix_valid;
    logic [9:0]  w_x, w_y;
    logic [19:0] w_addr;

    assign w_h_edge      = r_hs_d & ~r_hs;
    assign w_v_edge      = r_vs_d & ~r_vs;
    assign w_line_len    = sat_inc(r_hcnt);
    assign w_frame_lines = sat_inc(r_vcnt);
    assign w_timeout     = (w_hcnt == C_MAX);
    assign w_line_mis    = w_h_edge & (w_line_len != r_line_len);
    assign w_frame_mis   = w_v_edge & (w_frame_lines != r_frame_lines);

    // Register the pins once; keep the previous sync levels for edge detect.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_hs   <= 1'b0;
            r_hs_d <= 1'b0;
            r_vs   <= 1'b0;
            r_vs_d <= 1'b0;
            r_rgb  <= 12'd0;
        end else begin
            r_hs   <= vga.iVGA_H_SYNC;
            r_hs_d <= r_hs;
            r_vs   <= vga.iVGA_V_SYNC;
            r_vs_d <= r_vs;
            r_rgb  <= {vga.iVGA_R, vga.iVGA_G, vga.iVGA_B};
        end
    end

    // Position of the registered pixel: hcnt restarts on the H edge itself,
    // vcnt restarts on the first H edge at or after a V edge.
    always_comb begin
        w_hcnt = r_hcnt;
        w_vcnt = r_vcnt;
        if (w_h_edge) begin
            w_hcnt = 10'd0;
            if (w_v_edge || r_v_pend) begin
                w_vcnt = 10'd0;
            end else begin
                w_vcnt = sat_inc(r_vcnt);
            end
        end else begin
            w_hcnt = sat_inc(r_hcnt);
            w_vcnt = r_vcnt;
        end
    end

    // Line/frame counters plus the pending-V flag bridging a V edge that
    // arrives between H edges.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_hcnt   <= 10'd0;
            r_vcnt   <= 10'd0;
            r_v_pend <= 1'b0;
        end else begin
            r_hcnt <= w_hcnt;
            r_vcnt <= w_vcnt;
            if (w_h_edge) begin
                r_v_pend <= 1'b0;
            end else if (w_v_edge) begin
                r_v_pend <= 1'b1;
            end
        end
    end

    // Period measurements, refreshed at every edge regardless of lock.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_line_len    <= 10'd0;
            r_frame_lines <= 10'd0;
        end else begin
            if (w_h_edge) begin
                r_line_len <= w_line_len;
            end
            if (w_v_edge) begin
                r_frame_lines <= w_frame_lines;
            end
        end
    end

    // Lock FSM next state. The first frame after entering TRACK has no
    // predecessor to compare against, so it only needs consistent lines.
    always_comb begin
        w_state_nx    = r_state;
        w_match_nx    = r_match;
        w_first_nx    = r_first;
        w_line_bad_nx = r_line_bad;
        w_match_inc   = r_match + 3'd1;
        case (r_state)
            ST_SEARCH: begin
                if (w_v_edge) begin
                    w_state_nx    = ST_TRACK;
                    w_match_nx    = 3'd0;
                    w_first_nx    = 1'b1;
                    w_line_bad_nx = 1'b0;
                end else begin
                    w_state_nx = ST_SEARCH;
                end
            end
            ST_TRACK: begin
                if (w_v_edge) begin
                    w_first_nx    = 1'b0;
                    w_line_bad_nx = 1'b0;
                    if (!(r_line_bad || w_line_mis) && (r_first || !w_frame_mis)) begin
                        w_match_nx = w_match_inc;
                        if (w_match_inc == C_LOCK) begin
                            w_state_nx = ST_LOCKED;
                        end else begin
                            w_state_nx = ST_TRACK;
                        end
                    end else begin
                        w_match_nx = 3'd0;
                        w_state_nx = ST_TRACK;
                    end
                end else if (w_line_mis) begin
                    w_line_bad_nx = 1'b1;
                end else begin
                    w_line_bad_nx = r_line_bad;
                end
            end
            ST_LOCKED: begin
                if (w_line_mis || w_frame_mis || w_timeout) begin
                    w_state_nx = ST_SEARCH;
                    w_match_nx = 3'd0;
                end else begin
                    w_state_nx = ST_LOCKED;
                end
            end
            default: begin
                w_state_nx    = ST_SEARCH;
                w_match_nx    = 3'd0;
                w_first_nx    = 1'b0;
                w_line_bad_nx = 1'b0;
            end
        endcase
    end

    // Lock FSM state register.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state    <= ST_SEARCH;
            r_match    <= 3'd0;
            r_first    <= 1'b0;
            r_line_bad <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_match    <= w_match_nx;
            r_first    <= w_first_nx;
            r_line_bad <= w_line_bad_nx;
        end
    end

    // A pixel is emitted only if lock holds both now and after this cycle,
    // so the cycle that breaks lock already suppresses its strobe.
    assign w_keep      = (r_state == ST_LOCKED) && (w_state_nx == ST_LOCKED);
    assign w_active    = (w_hcnt >= C_H_LO) && (w_hcnt < C_H_HI) &&
                         (w_vcnt >= C_V_LO) && (w_vcnt < C_V_HI);
    assign w_pix_valid = w_active & w_keep;
    assign w_x         = w_hcnt - C_H_LO;
    assign w_y         = w_vcnt - C_V_LO;
    assign w_addr      = ({10'd0, w_y} * C_H_ACT) + {10'd0, w_x};

    // Output register: strobes every cycle, pixel fields hold between pixels.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_locked <= 1'b0;
            r_valid  <= 1'b0;
            r_fstart <= 1'b0;
            r_x      <= 10'd0;
            r_y      <= 10'd0;
            r_addr   <= 20'd0;
            r_data   <= 12'd0;
        end else begin
            r_locked <= (w_state_nx == ST_LOCKED);
            r_valid  <= w_pix_valid;
            r_fstart <= w_v_edge & w_keep;
            if (w_pix_valid) begin
                r_x    <= w_x;
                r_y    <= w_y;
                r_addr <= w_addr;
                r_data <= r_rgb;
            end
        end
    end

    assign vga.oCoord_X     = r_x;
    assign vga.oCoord_Y     = r_y;
    assign vga.oAddress     = r_addr;
    assign vga.oData        = r_data;
    assign vga.oPixel_Valid = r_valid;
    assign vga.oFrame_Start = r_fstart;
    assign vga.oLine_Len    = r_line_len;
    assign vga.oFrame_Lines = r_frame_lines;
    assign vga.oLocked      = r_locked;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on a scaled-down raster (100-cycle lines,
// 20-line frames) so that many frames fit in a short run. Expected pixels are
// queued as they are driven and matched against the DUT pixel strobe.
module tb_vga_sync_decoder;

    localparam int H_BACK   = 20;
    localparam int H_ACT    = 64;
    localparam int V_BACK   = 4;
    localparam int V_ACT    = 10;
    localparam int LINE     = 100;
    localparam int HS_LEN   = 12;
    localparam int LINES    = 20;
    localparam int VS_LINES = 2;

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [19:0] addr;
        logic [11:0] data;
        int          cyc;
    } exp_t;

    logic iCLK;
    logic iRST_N;
    int   cyc;
    int   n_tests;
    int   n_fail;
    exp_t sb_q[$];

    vga_sync_decoder_if bus ();

    vga_sync_decoder #(
        .H_BACK(H_BACK), .H_ACT(H_ACT), .V_BACK(V_BACK), .V_ACT(V_ACT), .LOCK_FRAMES(2)
    ) dut (
        .iCLK  (iCLK),
        .iRST_N(iRST_N),
        .vga   (bus)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    always @(posedge iCLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] pix(input int x, input int y);
        logic [9:0] xv;
        logic [9:0] yv;
        xv = 10'(x);
        yv = 10'(y);
        if (x == 5 && y == 7) return 12'hA3C;
        return {xv[3:0], yv[3:0], xv[7:4] ^ 4'h5};
    endfunction

    function automatic bit is_act(input int i, input int v);
        return (i >= H_BACK) && (i < H_BACK + H_ACT) && (v >= V_BACK) && (v < V_BACK + V_ACT);
    endfunction

    // Drive cycles [from,to) of raster line vline; optionally queue its pixels.
    task automatic drive_seg(input int vline, input int from, input int to, input bit push);
        exp_t e;
        logic [11:0] d;
        for (int i = from; i < to; i++) begin
            @(posedge iCLK);
            #1;
            bus.iVGA_H_SYNC = (i < HS_LEN) ? 1'b0 : 1'b1;
            bus.iVGA_V_SYNC = (vline < VS_LINES) ? 1'b0 : 1'b1;
            if (is_act(i, vline)) begin
                d = pix(i - H_BACK, vline - V_BACK);
                {bus.iVGA_R, bus.iVGA_G, bus.iVGA_B} = d;
                if (push) begin
                    e.x    = 10'(i - H_BACK);
                    e.y    = 10'(vline - V_BACK);
                    e.addr = 20'((vline - V_BACK) * H_ACT + (i - H_BACK));
                    e.data = d;
                    e.cyc  = cyc + 2;
                    sb_q.push_back(e);
                end
            end else begin
                {bus.iVGA_R, bus.iVGA_G, bus.iVGA_B} = 12'd0;
            end
        end
    endtask

    task automatic drive_lines(input int first, input int last, input bit push);
        for (int v = first; v < last; v++) drive_seg(v, 0, LINE, push);
    endtask

    task automatic drive_hold(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge iCLK);
            #1;
            bus.iVGA_H_SYNC = 1'b1;
            bus.iVGA_V_SYNC = 1'b1;
            {bus.iVGA_R, bus.iVGA_G, bus.iVGA_B} = 12'd0;
        end
    endtask

    // Scoreboard consumer: every strobe must match the oldest queued pixel.
    always @(negedge iCLK) begin : mon
        exp_t e;
        if (iRST_N && bus.oPixel_Valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_valid", 32'(bus.oPixel_Valid), 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("coord_x", 32'(bus.oCoord_X), 32'(e.x));
                chk("coord_y", 32'(bus.oCoord_Y), 32'(e.y));
                chk("address", 32'(bus.oAddress), 32'(e.addr));
                chk("data", 32'(bus.oData), 32'(e.data));
                chk("latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        int prev_len;
        int alt_len[5];
        alt_len = '{21, 20, 21, 20, 20};
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        iRST_N  = 1'b0;
        bus.iVGA_H_SYNC = 1'b1;
        bus.iVGA_V_SYNC = 1'b1;
        {bus.iVGA_R, bus.iVGA_G, bus.iVGA_B} = 12'd0;
        repeat (4) @(posedge iCLK);
        #1;
        chk("rst_locked", 32'(bus.oLocked), 32'd0);
        chk("rst_valid", 32'(bus.oPixel_Valid), 32'd0);
        chk("rst_line_len", 32'(bus.oLine_Len), 32'd0);
        chk("rst_frame_lines", 32'(bus.oFrame_Lines), 32'd0);
        chk("rst_addr", 32'(bus.oAddress), 32'd0);
        iRST_N = 1'b1;

        // Tail of a frame, then frames A and B; lock lands on the third V edge.
        drive_lines(17, LINES, 1'b0);
        drive_lines(0, LINES, 1'b0);
        chk("track_a_unlocked", 32'(bus.oLocked), 32'd0);
        chk("line_len_800eq", 32'(bus.oLine_Len), 32'(LINE));
        drive_lines(0, LINES, 1'b0);
        chk("track_b_unlocked", 32'(bus.oLocked), 32'd0);
        chk("frame_lines_a", 32'(bus.oFrame_Lines), 32'(LINES));

        // Frame C: lock, all active pixels expected (includes x=5,y=7 -> A3C).
        drive_seg(0, 0, 3, 1'b1);
        chk("lock_edge3", 32'(bus.oLocked), 32'd1);
        chk("fstart_not_locked_yet", 32'(bus.oFrame_Start), 32'd0);
        drive_seg(0, 3, LINE, 1'b1);
        drive_lines(1, LINES, 1'b1);
        chk("hold_x", 32'(bus.oCoord_X), 32'(H_ACT - 1));
        chk("hold_y", 32'(bus.oCoord_Y), 32'(V_ACT - 1));
        chk("hold_data", 32'(bus.oData), 32'(pix(H_ACT - 1, V_ACT - 1)));

        // Frame D: frame-start pulse, then line 8 one cycle short.
        drive_seg(0, 0, 3, 1'b1);
        chk("fstart_pulse", 32'(bus.oFrame_Start), 32'd1);
        drive_seg(0, 3, 4, 1'b1);
        chk("fstart_one_cycle", 32'(bus.oFrame_Start), 32'd0);
        drive_seg(0, 4, LINE, 1'b1);
        drive_lines(1, 8, 1'b1);
        drive_seg(8, 0, LINE - 1, 1'b1);
        drive_seg(9, 0, 2, 1'b0);
        chk("short_still_locked", 32'(bus.oLocked), 32'd1);
        drive_seg(9, 2, 3, 1'b0);
        chk("short_unlocked", 32'(bus.oLocked), 32'd0);
        chk("short_line_len", 32'(bus.oLine_Len), 32'(LINE - 1));
        drive_seg(9, 3, LINE, 1'b0);
        drive_lines(10, LINES, 1'b0);
        chk("short_stays_unlocked", 32'(bus.oLocked), 32'd0);

        // Frames E, F, G: relock on the third edge.
        drive_lines(0, LINES, 1'b0);
        drive_lines(0, LINES, 1'b0);
        chk("relock_f_unlocked", 32'(bus.oLocked), 32'd0);
        drive_seg(0, 0, 3, 1'b0);
        chk("relock_g", 32'(bus.oLocked), 32'd1);
        drive_seg(0, 3, LINE, 1'b1);
        drive_lines(1, LINES, 1'b1);

        // Frame H: hsync stuck high after line 5 -> timeout.
        drive_lines(0, 5, 1'b1);
        drive_seg(5, 0, LINE, 1'b1);
        drive_hold(1100);
        chk("timeout_unlocked", 32'(bus.oLocked), 32'd0);
        drive_seg(6, 0, 3, 1'b0);
        chk("timeout_line_len_sat", 32'(bus.oLine_Len), 32'd1023);
        drive_seg(6, 3, LINE, 1'b0);
        drive_lines(7, LINES, 1'b0);

        // Alternating frame heights never lock; frame count tracks each frame.
        prev_len = LINES;
        for (int f = 0; f < 5; f++) begin
            drive_seg(0, 0, 3, 1'b0);
            chk("alt_frame_lines", 32'(bus.oFrame_Lines), 32'(prev_len));
            chk("alt_unlocked", 32'(bus.oLocked), 32'd0);
            drive_seg(0, 3, LINE, 1'b0);
            drive_lines(1, alt_len[f], 1'b0);
            prev_len = alt_len[f];
        end
        drive_lines(0, LINES, 1'b0);
        chk("alt_recover_unlocked", 32'(bus.oLocked), 32'd0);
        drive_seg(0, 0, 3, 1'b0);
        chk("alt_recover_locked", 32'(bus.oLocked), 32'd1);
        drive_seg(0, 3, LINE, 1'b1);
        drive_lines(1, LINES, 1'b1);

        // Frame P: reset mid-line while locked.
        drive_lines(0, 6, 1'b1);
        drive_seg(6, 0, 15, 1'b0);
        iRST_N = 1'b0;
        #2;
        chk("arst_locked", 32'(bus.oLocked), 32'd0);
        chk("arst_valid", 32'(bus.oPixel_Valid), 32'd0);
        chk("arst_fstart", 32'(bus.oFrame_Start), 32'd0);
        chk("arst_x", 32'(bus.oCoord_X), 32'd0);
        chk("arst_y", 32'(bus.oCoord_Y), 32'd0);
        chk("arst_addr", 32'(bus.oAddress), 32'd0);
        chk("arst_data", 32'(bus.oData), 32'd0);
        chk("arst_line_len", 32'(bus.oLine_Len), 32'd0);
        chk("arst_frame_lines", 32'(bus.oFrame_Lines), 32'd0);
        drive_seg(6, 15, 40, 1'b0);
        iRST_N = 1'b1;
        drive_seg(6, 40, LINE, 1'b0);
        drive_lines(7, LINES, 1'b0);
        drive_lines(0, LINES, 1'b0);
        drive_lines(0, LINES, 1'b0);
        chk("post_rst_edge2_unlocked", 32'(bus.oLocked), 32'd0);
        drive_seg(0, 0, 3, 1'b0);
        chk("post_rst_relock", 32'(bus.oLocked), 32'd1);
        drive_seg(0, 3, LINE, 1'b1);
        drive_lines(1, LINES, 1'b1);
        drive_seg(0, 0, 5, 1'b0);

        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
